// File: rtl/key_entry_ctrl_if.sv
// Keypad-side bundle for key_entry_ctrl: timebase tick, key code and buttons
// in, and datapath strobes/display selects out. The slave modport is the controller.
interface key_entry_ctrl_if;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       shift;
  logic       show_new_time;
  logic       show_a;
  logic       load_new_a;
  logic       load_new_c;
  logic [2:0] digits;

  modport master (
    output one_second, key, alarm_button, time_button,
    input  shift, show_new_time, show_a, load_new_a, load_new_c, digits
  );

  modport slave (
    input  one_second, key, alarm_button, time_button,
    output shift, show_new_time, show_a, load_new_a, load_new_c, digits
  );
endinterface

// File: rtl/key_entry_ctrl.sv
// Alarm-clock keypad sequencer. Moore FSM that emits one shift per key press,
// times out idle entry sessions and commits the key buffer as alarm or clock time.
// All outputs come straight from flops; none depend combinationally on inputs.
module key_entry_ctrl #(
  parameter int         TIMEOUT_SEC = 10,
  parameter logic [3:0] NOKEY       = 4'hA
) (
  input logic             clock,
  input logic             reset,
  key_entry_ctrl_if.slave kif
);

  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_SEC - 1);
  localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT_SEC);
  localparam logic [2:0]    D_MAX  = 3'd4;

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    KEY_STORED = 3'd1,
    KEY_WAITED = 3'd2,
    KEY_ENTRY  = 3'd3,
    SHOW_ALARM = 3'd4,
    SET_ALARM  = 3'd5,
    SET_TIME   = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    digits_q, digits_d;
  logic          shift_q, shift_d;
  logic          snt_q, snt_d;
  logic          show_a_q, show_a_d;
  logic          load_a_q, load_a_d;
  logic          load_c_q, load_c_d;

  logic key_hit;
  logic timeout;
  logic in_session;

  // Next state, inactivity timer, digit count and next-state output decode.
  always_comb begin
    key_hit    = (kif.key != NOKEY);
    timeout    = kif.one_second && (timer_q == T_LAST);
    in_session = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);

    state_d = state_q;
    case (state_q)
      SHOW_TIME: begin
        if (kif.alarm_button) state_d = SHOW_ALARM;
        else if (key_hit)     state_d = KEY_STORED;
      end
      // single cycle here guarantees one shift per press
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_hit)     state_d = KEY_ENTRY;
        else if (timeout) state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        // alarm wins when both commit buttons are pressed together
        if (kif.alarm_button)     state_d = SET_ALARM;
        else if (kif.time_button) state_d = SET_TIME;
        else if (key_hit)         state_d = KEY_STORED;
        else if (timeout)         state_d = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!kif.alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM: state_d = SHOW_TIME;
      SET_TIME:  state_d = SHOW_TIME;
      default:   state_d = SHOW_TIME;
    endcase

    // timer restarts on every state change, counts ticks only while waiting on the user
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = '0;
    else if (in_session && kif.one_second && (timer_q != T_SAT))
      timer_d = timer_q + 1'b1;

    // digit count is zero whenever the clock view is (re)entered; buffer itself is untouched
    digits_d = digits_q;
    if ((state_q == SHOW_TIME) || (state_d == SHOW_TIME))
      digits_d = '0;
    else if ((state_q == KEY_STORED) && (digits_q != D_MAX))
      digits_d = digits_q + 1'b1;

    // outputs are registered decodes of the state being entered
    shift_d  = (state_d == KEY_STORED);
    snt_d    = (state_d == KEY_STORED) || (state_d == KEY_WAITED) ||
               (state_d == KEY_ENTRY);
    show_a_d = (state_d == SHOW_ALARM);
    load_a_d = (state_d == SET_ALARM);
    load_c_d = (state_d == SET_TIME);
  end

  // State, counters and Moore outputs; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= SHOW_TIME;
      timer_q  <= '0;
      digits_q <= '0;
      shift_q  <= 1'b0;
      snt_q    <= 1'b0;
      show_a_q <= 1'b0;
      load_a_q <= 1'b0;
      load_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      digits_q <= digits_d;
      shift_q  <= shift_d;
      snt_q    <= snt_d;
      show_a_q <= show_a_d;
      load_a_q <= load_a_d;
      load_c_q <= load_c_d;
    end
  end

  assign kif.shift         = shift_q;
  assign kif.show_new_time = snt_q;
  assign kif.show_a        = show_a_q;
  assign kif.load_new_a    = load_a_q;
  assign kif.load_new_c    = load_c_q;
  assign kif.digits        = digits_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl: press/release sequences, commits,
// inactivity timeout, alarm display, digit saturation and async reset.
module tb_key_entry_ctrl;

  localparam logic [3:0] NOKEY = 4'hA;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   shift_cnt = 0;
  int   load_a_cnt = 0;
  int   load_c_cnt = 0;
  int   show_a_cnt = 0;

  key_entry_ctrl_if kif ();

  key_entry_ctrl #(.TIMEOUT_SEC(10), .NOKEY(NOKEY)) dut (
    .clock (clock),
    .reset (reset),
    .kif   (kif)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // advance one edge, then sample 1ns later and tally pulse outputs
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      shift_cnt  += int'(kif.shift);
      load_a_cnt += int'(kif.load_new_a);
      load_c_cnt += int'(kif.load_new_c);
      show_a_cnt += int'(kif.show_a);
    end
  endtask

  task automatic press(input logic [3:0] k);
    kif.key = k;
    step(2);
    kif.key = NOKEY;
    step(1);
  endtask

  task automatic sec_tick();
    kif.one_second = 1'b1;
    step(1);
    kif.one_second = 1'b0;
    step(1);
  endtask

  task automatic clr_cnt();
    shift_cnt = 0; load_a_cnt = 0; load_c_cnt = 0; show_a_cnt = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".shift"}, {31'd0, kif.shift}, 0);
    chk({tag, ".snt"},   {31'd0, kif.show_new_time}, 0);
    chk({tag, ".showa"}, {31'd0, kif.show_a}, 0);
    chk({tag, ".lda"},   {31'd0, kif.load_new_a}, 0);
    chk({tag, ".ldc"},   {31'd0, kif.load_new_c}, 0);
    chk({tag, ".dig"},   {29'd0, kif.digits}, 0);
  endtask

  initial begin
    kif.key = NOKEY;
    kif.one_second = 1'b0;
    kif.alarm_button = 1'b0;
    kif.time_button = 1'b0;
    #2;
    chk_idle("reset");
    step(2);
    reset = 1'b1;
    step(1);
    chk_idle("post_reset");

    // key held 5 cycles then released: one shift, digits=1, in entry
    clr_cnt();
    kif.key = 4'd3;
    step(1);
    chk("t2.shift_first", {31'd0, kif.shift}, 1);
    step(4);
    kif.key = NOKEY;
    step(1);
    chk("t2.shifts", shift_cnt, 1);
    chk("t2.digits", {29'd0, kif.digits}, 1);
    chk("t2.snt", {31'd0, kif.show_new_time}, 1);

    // asynchronous reset mid-entry, sampled between clock edges
    reset = 1'b0;
    #2;
    chk_idle("t1");
    step(1);
    reset = 1'b1;
    step(1);
    chk_idle("t1.after");

    // four digits then commit as clock time
    clr_cnt();
    press(4'd1); press(4'd2); press(4'd3); press(4'd0);
    chk("t3.shifts", shift_cnt, 4);
    chk("t3.digits", {29'd0, kif.digits}, 4);
    kif.time_button = 1'b1;
    step(1);
    chk("t3.ldc", {31'd0, kif.load_new_c}, 1);
    chk("t3.lda", {31'd0, kif.load_new_a}, 0);
    kif.time_button = 1'b0;
    step(1);
    chk_idle("t3.show_time");
    step(3);
    chk("t3.ldc_count", load_c_cnt, 1);
    chk("t3.lda_count", load_a_cnt, 0);

    // inactivity: tenth tick aborts without a load
    clr_cnt();
    press(4'd7);
    for (int i = 0; i < 9; i++) sec_tick();
    chk("t4.still_in", {31'd0, kif.show_new_time}, 1);
    kif.one_second = 1'b1;
    step(1);
    kif.one_second = 1'b0;
    chk_idle("t4.abort");
    step(2);
    chk("t4.no_load", load_a_cnt + load_c_cnt, 0);

    // nine ticks then a key restarts the timer
    press(4'd7);
    for (int i = 0; i < 9; i++) sec_tick();
    press(4'd5);
    chk("t4.after_key", {31'd0, kif.show_new_time}, 1);
    chk("t4.digits", {29'd0, kif.digits}, 2);
    for (int i = 0; i < 9; i++) sec_tick();
    chk("t4.timer_cleared", {31'd0, kif.show_new_time}, 1);
    sec_tick();
    chk("t4.abort2", {31'd0, kif.show_new_time}, 0);

    // alarm display while held
    clr_cnt();
    kif.alarm_button = 1'b1;
    step(3);
    kif.alarm_button = 1'b0;
    step(1);
    chk("t5.show_a_cycles", show_a_cnt, 3);
    chk("t5.show_a_off", {31'd0, kif.show_a}, 0);

    // five digits saturate the count, then both buttons commit as alarm
    clr_cnt();
    for (int i = 0; i < 5; i++) press(4'(i + 4));
    chk("t6.shifts", shift_cnt, 5);
    chk("t6.digits", {29'd0, kif.digits}, 4);
    kif.alarm_button = 1'b1;
    kif.time_button = 1'b1;
    step(1);
    chk("t5.lda", {31'd0, kif.load_new_a}, 1);
    chk("t5.ldc", {31'd0, kif.load_new_c}, 0);
    kif.alarm_button = 1'b0;
    kif.time_button = 1'b0;
    step(3);
    chk("t5.lda_count", load_a_cnt, 1);
    chk("t5.ldc_count", load_c_cnt, 0);
    chk_idle("t5.end");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
